// File: rtl/ls_exec_unit_pkg.sv
// Shared definitions for the load/store execution stage: widths, opcode and
// size encodings, FSM states and opcode decode helpers.
package ls_exec_unit_pkg;

    localparam int unsigned DATA_LEN   = 32;
    localparam int unsigned OPENUM_LEN = 6;
    localparam int unsigned ROB_LEN    = 4;

    localparam logic [OPENUM_LEN-1:0] OP_LB  = 6'd11;
    localparam logic [OPENUM_LEN-1:0] OP_LH  = 6'd12;
    localparam logic [OPENUM_LEN-1:0] OP_LW  = 6'd13;
    localparam logic [OPENUM_LEN-1:0] OP_LBU = 6'd14;
    localparam logic [OPENUM_LEN-1:0] OP_LHU = 6'd15;
    localparam logic [OPENUM_LEN-1:0] OP_SB  = 6'd16;
    localparam logic [OPENUM_LEN-1:0] OP_SH  = 6'd17;
    localparam logic [OPENUM_LEN-1:0] OP_SW  = 6'd18;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [DATA_LEN-1:0] ZERO_WORD = '0;
    localparam logic [ROB_LEN:0]    ZERO_ROB  = '0;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } ls_state_e;

    function automatic logic is_ls_op(input logic [OPENUM_LEN-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_store_op(input logic [OPENUM_LEN-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic [1:0] op_size(input logic [OPENUM_LEN-1:0] op);
        logic [1:0] size;
        size = SIZE_W;
        if (op inside {OP_LB, OP_LBU, OP_SB}) size = SIZE_B;
        if (op inside {OP_LH, OP_LHU, OP_SH}) size = SIZE_H;
        return size;
    endfunction

endpackage

// File: rtl/ls_exec_unit_load_extend.sv
// Sign/zero extension of raw memory-controller load data by opcode.
// Non-load opcodes (stores, unknown) produce zero.
module ls_load_extend #(
    parameter int unsigned DATA_LEN   = 32,
    parameter int unsigned OPENUM_LEN = 6
) (
    input  logic [OPENUM_LEN-1:0] openum_i,
    input  logic [DATA_LEN-1:0]   raw_i,
    output logic [DATA_LEN-1:0]   ext_o
);
    import ls_exec_unit_pkg::*;

    always_comb begin
        ext_o = '0;
        case (openum_i)
            OP_LB:   ext_o = {{(DATA_LEN-8){raw_i[7]}}, raw_i[7:0]};
            OP_LH:   ext_o = {{(DATA_LEN-16){raw_i[15]}}, raw_i[15:0]};
            OP_LBU:  ext_o = {{(DATA_LEN-8){1'b0}}, raw_i[7:0]};
            OP_LHU:  ext_o = {{(DATA_LEN-16){1'b0}}, raw_i[15:0]};
            OP_LW:   ext_o = raw_i;
            default: ext_o = '0;
        endcase
    end

endmodule

// File: rtl/ls_exec_unit.sv
// Load/store execution stage: holds one op, issues it to the memory controller,
// and broadcasts the (extended) result on the CDB when the request completes.
module ls_exec_unit #(
    parameter int unsigned DATA_LEN   = ls_exec_unit_pkg::DATA_LEN,
    parameter int unsigned OPENUM_LEN = ls_exec_unit_pkg::OPENUM_LEN,
    parameter int unsigned ROB_LEN    = ls_exec_unit_pkg::ROB_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rollback,
    input  logic                  ena_from_lsb,
    input  logic [OPENUM_LEN-1:0] openum_from_lsb,
    input  logic [DATA_LEN-1:0]   V1_from_lsb,
    input  logic [DATA_LEN-1:0]   V2_from_lsb,
    input  logic [DATA_LEN-1:0]   imm_from_lsb,
    input  logic [ROB_LEN:0]      rob_id_from_lsb,
    output logic                  busy_to_lsb,
    output logic                  ena_to_mc,
    output logic                  wr_to_mc,
    output logic [DATA_LEN-1:0]   addr_to_mc,
    output logic [DATA_LEN-1:0]   data_to_mc,
    output logic [1:0]            size_to_mc,
    input  logic                  done_from_mc,
    input  logic [DATA_LEN-1:0]   data_from_mc,
    output logic                  valid_to_cdb,
    output logic [ROB_LEN:0]      rob_id_to_cdb,
    output logic [DATA_LEN-1:0]   result_to_cdb
);
    import ls_exec_unit_pkg::*;

    ls_state_e             state_q, state_d;
    logic [OPENUM_LEN-1:0] openum_q, openum_d;
    logic [ROB_LEN:0]      rob_q, rob_d;
    logic                  wr_q, wr_d;
    logic [DATA_LEN-1:0]   addr_q, addr_d;
    logic [DATA_LEN-1:0]   data_q, data_d;
    logic [1:0]            size_q, size_d;
    logic                  ena_mc_q, ena_mc_d;
    logic                  busy_q, busy_d;
    logic                  squash_q, squash_d;
    logic                  cdb_valid_q, cdb_valid_d;
    logic [ROB_LEN:0]      cdb_rob_q, cdb_rob_d;
    logic [DATA_LEN-1:0]   cdb_res_q, cdb_res_d;

    logic                  accept;
    logic                  abort;
    logic [DATA_LEN-1:0]   ext_data;

    ls_load_extend #(
        .DATA_LEN   (DATA_LEN),
        .OPENUM_LEN (OPENUM_LEN)
    ) u_extend (
        .openum_i (openum_q),
        .raw_i    (data_from_mc),
        .ext_o    (ext_data)
    );

    // Loads are aborted by rollback; a held store is already committed and
    // must finish, so rollback only suppresses its broadcast.
    assign accept = ena_from_lsb && !rollback && is_ls_op(openum_from_lsb);
    assign abort  = rollback && !wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            openum_q    <= '0;
            rob_q       <= ZERO_ROB;
            wr_q        <= 1'b0;
            addr_q      <= ZERO_WORD;
            data_q      <= ZERO_WORD;
            size_q      <= '0;
            ena_mc_q    <= 1'b0;
            busy_q      <= 1'b0;
            squash_q    <= 1'b0;
            cdb_valid_q <= 1'b0;
            cdb_rob_q   <= ZERO_ROB;
            cdb_res_q   <= ZERO_WORD;
        end else begin
            state_q     <= state_d;
            openum_q    <= openum_d;
            rob_q       <= rob_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            size_q      <= size_d;
            ena_mc_q    <= ena_mc_d;
            busy_q      <= busy_d;
            squash_q    <= squash_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_res_q   <= cdb_res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_REQ;
            ST_REQ:  if (abort || done_from_mc) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        openum_d    = openum_q;
        rob_d       = rob_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        size_d      = size_q;
        ena_mc_d    = ena_mc_q;
        busy_d      = busy_q;
        squash_d    = squash_q;
        cdb_valid_d = 1'b0;
        cdb_rob_d   = cdb_rob_q;
        cdb_res_d   = cdb_res_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    openum_d = openum_from_lsb;
                    rob_d    = rob_id_from_lsb;
                    wr_d     = is_store_op(openum_from_lsb);
                    addr_d   = V1_from_lsb + imm_from_lsb;
                    data_d   = V2_from_lsb;
                    size_d   = op_size(openum_from_lsb);
                    ena_mc_d = 1'b1;
                    busy_d   = 1'b1;
                    squash_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (abort) begin
                    ena_mc_d = 1'b0;
                    busy_d   = 1'b0;
                end else begin
                    if (rollback) squash_d = 1'b1;
                    if (done_from_mc) begin
                        ena_mc_d    = 1'b0;
                        busy_d      = 1'b0;
                        cdb_valid_d = !(squash_q || rollback);
                        cdb_rob_d   = rob_q;
                        cdb_res_d   = wr_q ? ZERO_WORD : ext_data;
                    end
                end
            end
            default: begin
                ena_mc_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign busy_to_lsb   = busy_q;
    assign ena_to_mc     = ena_mc_q;
    assign wr_to_mc      = wr_q;
    assign addr_to_mc    = addr_q;
    assign data_to_mc    = data_q;
    assign size_to_mc    = size_q;
    assign valid_to_cdb  = cdb_valid_q;
    assign rob_id_to_cdb = cdb_rob_q;
    assign result_to_cdb = cdb_res_q;

endmodule
